// File: rtl/fastram_autoconfig_ctrl.sv
// -----------------------------------------------------------------------------
// fastram_autoconfig_ctrl
//
// Zorro II autoconfig FastRAM controller for A500/A1000/A2000/CDTV expansion
// boards. It sits between the 68000 bus and a DRAM array of BANKS x 1MB slots
// mapped into $200000-$9FFFFF. Autoconfig offers the largest power-of-two
// block that fits the free memory. Each shut-up halves the offer. After a
// block is placed, the remaining memory is offered again as a further block.
// DRAM accesses use a RAS/CAS FSM with a row/column address mux. A timer
// drives CAS-before-RAS refresh.
//
// Optional feature macro: CDTV_WAIT_EN. When defined, the autoconfig slot
// stays closed until a write to $E80048 is seen. That write configures the
// CDTV DMAC, which is first in the chain.
//
// Ports
//   CLK            in   68000 bus clock (7MHz)
//   reset          in   asynchronous, active-low
//   CFGINn         in   autoconfig chain input
//   ASn/UDSn/LDSn  in   68000 address and data strobes
//   RWn            in   68000 read/write
//   ADDR[23:1]     in   68000 address
//   DBUS_I[3:0]    in   data bus D[15:12] (autoconfig writes)
//   DBUS_O[3:0]    out  autoconfig read nibble
//   DBUS_OE        out  drive enable for D[15:12]
//   CFGOUTn        out  autoconfig chain output
//   MADDR[11:0]    out  DRAM row/column address
//   RASn/UCASn/LCASn out DRAM strobes
//   OEn/MEMWn      out  data buffer enable and DRAM write enable
// -----------------------------------------------------------------------------
module fastram_autoconfig_ctrl #(
    parameter int          BANKS       = 8,
    parameter int          REFRESH_DIV = 108,
    parameter logic [15:0] MFG_ID      = 16'h07DB,
    parameter logic [7:0]  PROD_ID     = 8'd70,
    parameter logic [15:0] SERIAL      = 16'd420
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        CFGINn,
    input  logic        ASn,
    input  logic        UDSn,
    input  logic        LDSn,
    input  logic        RWn,
    input  logic [23:1] ADDR,
    input  logic [3:0]  DBUS_I,
    output logic [3:0]  DBUS_O,
    output logic        DBUS_OE,
    output logic        CFGOUTn,
    output logic [11:0] MADDR,
    output logic        RASn,
    output logic        UCASn,
    output logic        LCASn,
    output logic        OEn,
    output logic        MEMWn
);

    function automatic logic [3:0] pow2_floor(input logic [3:0] n);
        if (n >= 4'd8)      return 4'd8;
        else if (n >= 4'd4) return 4'd4;
        else if (n >= 4'd2) return 4'd2;
        else if (n >= 4'd1) return 4'd1;
        else                return 4'd0;
    endfunction

    localparam logic [3:0] BANKS_MB   = 4'(BANKS);
    localparam logic [3:0] OFFER_INIT = pow2_floor(BANKS_MB);
    localparam logic [6:0] REG_BASE   = 7'h24;
    localparam logic [6:0] REG_SHUTUP = 7'h26;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ROW     = 3'd1;
    localparam logic [2:0] COL     = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] REF_CAS = 3'd4;
    localparam logic [2:0] REF_RAS = 3'd5;
    localparam logic [2:0] REF_END = 3'd6;

    // NOTE: reset asserts asynchronously but releases through two flops, so
    // every state flop leaves reset on the same clean CLK edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [3:0]  offer, free_mb, slot_lo, reg_nib;
    logic [7:0]  alloc, alloc_mask;
    logic        done, slot, hit, as_q, uds_q, slot_gate, cfg_wr, base_ok;
    logic [2:0]  state;
    logic [1:0]  pend;
    logic [15:0] ref_cnt;
    logic        ref_wrap;
    logic [3:0]  ram_slot;
    logic [3:0]  free_after;

`ifdef CDTV_WAIT_EN
    // The DMAC sits ahead of us in the chain; stay silent until its base
    // register write has gone past.
    logic cdtv_seen;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            cdtv_seen <= 1'b0;
        else if (!ASn && !RWn && !UDSn && uds_q && ADDR == 23'h740024)
            cdtv_seen <= 1'b1;
    end
    assign slot_gate = cdtv_seen;
`else
    assign slot_gate = 1'b1;
`endif

    // Bus decode is sampled on the falling edge so it is stable for the
    // rising-edge FSMs that follow.
    assign ram_slot = ADDR[23:20] - 4'd2;   // $2x..$9x -> 0..7, others wrap above 7

    always_ff @(negedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            slot  <= 1'b0;
            hit   <= 1'b0;
            MADDR <= 12'h000;
        end else begin
            slot  <= (ADDR[23:16] == 8'hE8) && !ASn && !CFGINn && !done && slot_gate;
            hit   <= !ASn && (ram_slot <= 4'd7) && alloc[ram_slot[2:0]];
            MADDR <= (state == COL || state == HOLD) ? {2'b00, ADDR[10:1]} : ADDR[22:11];
        end
    end

    assign DBUS_OE = slot & RWn & ~UDSn;
    assign OEn     = ~hit;
    assign MEMWn   = RWn | (UDSn & LDSn);

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    always_comb begin
        reg_nib = 4'hF;
        case (ADDR[7:1])
            7'h00: reg_nib = 4'b1110;      // Zorro II, link into free pool, no ROM
            7'h01: case (offer)
                       4'd8:    reg_nib = 4'b0000;
                       4'd4:    reg_nib = 4'b0111;
                       4'd2:    reg_nib = 4'b0110;
                       default: reg_nib = 4'b0101;
                   endcase
            7'h02: reg_nib = ~PROD_ID[7:4];
            7'h03: reg_nib = ~PROD_ID[3:0];
            7'h08: reg_nib = ~MFG_ID[15:12];
            7'h09: reg_nib = ~MFG_ID[11:8];
            7'h0A: reg_nib = ~MFG_ID[7:4];
            7'h0B: reg_nib = ~MFG_ID[3:0];
            7'h10: reg_nib = ~SERIAL[15:12];
            7'h11: reg_nib = ~SERIAL[11:8];
            7'h12: reg_nib = ~SERIAL[7:4];
            7'h13: reg_nib = ~SERIAL[3:0];
            default: reg_nib = 4'hF;
        endcase
    end

    // Base write: nibble N places the offered block at slots N-2 onwards.
    assign slot_lo    = DBUS_I - 4'd2;
    assign base_ok    = (DBUS_I >= 4'd2) && (DBUS_I <= 4'd9)
                     && ((slot_lo & (offer - 4'd1)) == 4'd0)
                     && (({1'b0, slot_lo} + {1'b0, offer}) <= 5'(BANKS));
    assign free_after = free_mb - offer;
    assign cfg_wr     = slot && !RWn && !UDSn && uds_q;   // UDSn falling edge

    always_comb begin
        alloc_mask = '0;
        for (int i = 0; i < 8; i++)
            if (i >= int'(slot_lo) && i < int'(slot_lo) + int'(offer))
                alloc_mask[i] = 1'b1;
    end

    // NOTE: state flops use non-blocking assignments only, so every block
    // sees the pre-edge value of every other register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            offer   <= OFFER_INIT;
            free_mb <= BANKS_MB;
            alloc   <= '0;
            done    <= 1'b0;
            CFGOUTn <= 1'b1;
            DBUS_O  <= 4'hF;
            as_q    <= 1'b1;
            uds_q   <= 1'b1;
        end else begin
            as_q   <= ASn;
            uds_q  <= UDSn;
            DBUS_O <= reg_nib;
            if (!as_q && ASn)
                CFGOUTn <= ~done;
            if (cfg_wr) begin
                case (ADDR[7:1])
                    REG_SHUTUP: begin
                        if (offer == 4'd1) done  <= 1'b1;
                        else               offer <= offer >> 1;
                    end
                    REG_BASE: begin
                        if (!base_ok) begin
                            done <= 1'b1;
                        end else begin
                            alloc   <= alloc | alloc_mask;
                            free_mb <= free_after;
                            if (free_after == 4'd0)
                                done <= 1'b1;
                            // A re-offer never grows past the block just
                            // placed, so a size the host shut up is not
                            // offered again.
                            else if (pow2_floor(free_after) < offer)
                                offer <= pow2_floor(free_after);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ref_wrap = (ref_cnt == 16'(REFRESH_DIV - 1));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)        ref_cnt <= '0;
        else if (ref_wrap) ref_cnt <= '0;
        else               ref_cnt <= ref_cnt + 16'd1;
    end

    // Access/refresh FSM. CAS is asserted one cycle into COL, after MADDR has
    // switched to the column on the preceding falling edge.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= 2'd0;
            RASn  <= 1'b1;
            UCASn <= 1'b1;
            LCASn <= 1'b1;
        end else begin
            // A wrap coinciding with REF_END leaves pend unchanged.
            case ({ref_wrap, state == REF_END})
                2'b10:   if (pend != 2'd3) pend <= pend + 2'd1;
                2'b01:   pend <= pend - 2'd1;
                default: ;
            endcase
            case (state)
                IDLE: begin
                    if (pend != 2'd0 && ASn) begin
                        state <= REF_CAS;
                        UCASn <= 1'b0;
                        LCASn <= 1'b0;
                    end else if (hit) begin
                        state <= ROW;
                        RASn  <= 1'b0;
                    end
                end
                ROW: state <= COL;
                COL: begin
                    if (ASn) begin
                        state <= IDLE;
                        RASn  <= 1'b1;
                        UCASn <= 1'b1;
                        LCASn <= 1'b1;
                    end else if (!UCASn || !LCASn) begin
                        state <= HOLD;
                    end else begin
                        UCASn <= UDSn;
                        LCASn <= LDSn;
                    end
                end
                HOLD: begin
                    if (ASn) begin
                        state <= IDLE;
                        RASn  <= 1'b1;
                        UCASn <= 1'b1;
                        LCASn <= 1'b1;
                    end
                end
                REF_CAS: begin
                    state <= REF_RAS;
                    RASn  <= 1'b0;
                end
                REF_RAS: begin
                    state <= REF_END;
                    RASn  <= 1'b1;
                    UCASn <= 1'b1;
                    LCASn <= 1'b1;
                end
                default: state <= IDLE;   // REF_END: one precharge cycle
            endcase
        end
    end

endmodule
